// File: rtl/pdm_pkg.sv
// Shared sizing helpers for the PDM CIC decimator: internal CIC width,
// output scaling shift, saturation limits and parameter sanity checks.
package pdm_pkg;

  function automatic int cic_width(input int order, input int log2_dec);
    return order * log2_dec + 2;
  endfunction

  function automatic int cic_shift(input int width, input int out_width);
    return width - out_width - 1;
  endfunction

  function automatic longint sat_max(input int out_width);
    return (64'sd1 <<< (out_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int out_width);
    return -(64'sd1 <<< (out_width - 1));
  endfunction

  // OUT_WIDTH is capped at N*L+1 so the scaling shift never goes negative.
  function automatic bit params_ok(input int channels, input int decimation,
                                   input int order, input int out_width);
    int l;
    l = $clog2(decimation);
    return (channels >= 1) && (channels <= 8) &&
           (decimation >= 8) && (decimation <= 256) &&
           ((1 << l) == decimation) &&
           (order >= 1) && (order <= 4) &&
           (out_width >= 2) && (out_width <= order * l + 1);
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PCM sample stream with valid/ready handshake, driven by the decimator.
interface pdm_cic_decimator_if #(
  parameter int CHANNELS  = 2,
  parameter int OUT_WIDTH = 16
) ();

  logic [CHANNELS*OUT_WIDTH-1:0] pcm;
  logic                          pcm_valid;
  logic                          pcm_ready;

  modport master (output pcm, output pcm_valid, input pcm_ready);
  modport slave  (input pcm, input pcm_valid, output pcm_ready);

endinterface

// File: rtl/pdm_cic_channel.sv
// One channel of the CIC decimator: N integrators at the PDM rate, N combs at
// the frame rate, then scaling to the PCM width with saturation.
module pdm_cic_channel
  import pdm_pkg::*;
#(
  parameter int ORDER     = 3,
  parameter int LOG2_DEC  = 6,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        pdm_clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        dump,
  input  logic                        pdm_bit,
  output logic signed [OUT_WIDTH-1:0] result
);

  localparam int W     = cic_width(ORDER, LOG2_DEC);
  localparam int SHIFT = cic_shift(W, OUT_WIDTH);
  localparam logic signed [W-1:0] HI = W'(sat_max(OUT_WIDTH));
  localparam logic signed [W-1:0] LO = W'(sat_min(OUT_WIDTH));

  logic signed [W-1:0] x;
  logic signed [W-1:0] integ      [ORDER];
  logic signed [W-1:0] integ_next [ORDER];
  logic signed [W-1:0] comb_dly   [ORDER];
  logic signed [W-1:0] comb_in    [ORDER];
  logic signed [W-1:0] comb_out   [ORDER];
  logic signed [W-1:0] scaled;

  // The comb chain sees the integrator value that already includes this
  // cycle's bit, so a frame's result covers all DECIMATION of its bits.
  always_comb begin
    x = pdm_bit ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    integ_next[0] = integ[0] + x;
    for (int i = 1; i < ORDER; i++) begin
      integ_next[i] = integ[i] + integ_next[i-1];
    end
    comb_in[0]  = integ_next[ORDER-1];
    comb_out[0] = comb_in[0] - comb_dly[0];
    for (int i = 1; i < ORDER; i++) begin
      comb_in[i]  = comb_out[i-1];
      comb_out[i] = comb_in[i] - comb_dly[i];
    end
    scaled = comb_out[ORDER-1] >>> SHIFT;
    if (scaled > HI) begin
      result = HI[OUT_WIDTH-1:0];
    end else if (scaled < LO) begin
      result = LO[OUT_WIDTH-1:0];
    end else begin
      result = scaled[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge pdm_clk) begin
    if (reset) begin
      for (int i = 0; i < ORDER; i++) begin
        integ[i]    <= '0;
        comb_dly[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ORDER; i++) begin
        if (enable) integ[i] <= integ_next[i];
        if (dump)   comb_dly[i] <= comb_in[i];
      end
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Multi-channel PDM-to-PCM CIC decimator: shared frame counter, settling
// suppression, PCM valid/ready handshake with sticky overrun, and pcm_clk.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DECIMATION = 64,
  parameter int CIC_ORDER  = 3,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                pdm_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] pdm,
  pdm_cic_decimator_if.master pcm_bus,
  output logic                pcm_clk,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int L  = $clog2(DECIMATION);
  localparam int SW = $clog2(CIC_ORDER + 1);

  if (!params_ok(CHANNELS, DECIMATION, CIC_ORDER, OUT_WIDTH)) begin : g_param_check
    $error("pdm_cic_decimator: parameter out of supported range");
  end

  logic [L-1:0]                count;
  logic [SW-1:0]               settle;
  logic                        frame_done;
  logic                        publish;
  logic signed [OUT_WIDTH-1:0] results [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pdm_cic_channel #(
      .ORDER     (CIC_ORDER),
      .LOG2_DEC  (L),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_channel (
      .pdm_clk (pdm_clk),
      .reset   (reset),
      .enable  (enable),
      .dump    (frame_done),
      .pdm_bit (pdm[c]),
      .result  (results[c])
    );
  end

  // Results are suppressed until the combs have been flushed CIC_ORDER times.
  always_comb begin
    frame_done = enable && (count == L'(DECIMATION - 1));
    publish    = frame_done && (settle == SW'(CIC_ORDER));
  end

  assign pcm_clk = count[L-1];

  always_ff @(posedge pdm_clk) begin
    if (reset) begin
      count  <= '0;
      settle <= '0;
    end else if (enable) begin
      count <= count + L'(1);
      if (frame_done && (settle != SW'(CIC_ORDER))) begin
        settle <= settle + SW'(1);
      end
    end
  end

  // A fresh result always wins over a pending one; losing an unaccepted
  // sample is what overrun records, and that event beats a same-cycle clear.
  always_ff @(posedge pdm_clk) begin
    if (reset) begin
      pcm_bus.pcm       <= '0;
      pcm_bus.pcm_valid <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (publish) begin
        for (int c = 0; c < CHANNELS; c++) begin
          pcm_bus.pcm[c*OUT_WIDTH +: OUT_WIDTH] <= results[c];
        end
        pcm_bus.pcm_valid <= 1'b1;
      end else if (pcm_bus.pcm_valid && pcm_bus.pcm_ready) begin
        pcm_bus.pcm_valid <= 1'b0;
      end
      if (publish && pcm_bus.pcm_valid && !pcm_bus.pcm_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
